// File: rtl/tms_pulse_pkg.sv
// tms_pulse_pkg: shared types, default sizes and channel-rotation helper for tms_pulse_seq
package tms_pulse_pkg;
  localparam int DEF_CLK_PER_US = 50;
  localparam int DEF_N_CH = 5;
  localparam int DEF_TW = 24;
  localparam int DEF_CW = 8;
  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
  typedef struct packed {
    logic [DEF_TW-1:0] on_time;
    logic [DEF_TW-1:0] pulse_period;
    logic [DEF_CW-1:0] pulses;
    logic [DEF_TW-1:0] burst_period;
    logic [DEF_CW-1:0] bursts;
    logic [DEF_N_CH-1:0] ch_mask;
    logic rotate;
  } cfg_t;
  // Lowest mask bit strictly above the one-hot cur, wrapping to the lowest set bit; cur=0 gives the lowest.
  function automatic logic [DEF_N_CH-1:0] next_ch(input logic [DEF_N_CH-1:0] mask, input logic [DEF_N_CH-1:0] cur);
    logic [DEF_N_CH-1:0] hi;
    hi = mask & ~((cur << 1) - DEF_N_CH'(1));
    return hi != '0 ? hi & (-hi) : mask & (-mask);
  endfunction
endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen: prescaler giving a one-cycle tick every DIV clocks, restartable
module us_tick_gen #(
  parameter int DIV = 50
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cnt <= '0;
    else cnt <= restart || tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/tms_pulse_seq.sv
// tms_pulse_seq: multi-channel IGBT pulse/burst sequencer timed on a 1 us tick
module tms_pulse_seq
  import tms_pulse_pkg::*;
#(
  parameter int CLK_PER_US = DEF_CLK_PER_US,
  parameter int N_CH = DEF_N_CH,
  parameter int TW = DEF_TW,
  parameter int CW = DEF_CW
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [TW-1:0]   cfg_on_time,
  input  logic [TW-1:0]   cfg_pulse_period,
  input  logic [CW-1:0]   cfg_pulses,
  input  logic [TW-1:0]   cfg_burst_period,
  input  logic [CW-1:0]   cfg_bursts,
  input  logic [N_CH-1:0] cfg_ch_mask,
  input  logic            cfg_rotate,
  output logic [N_CH-1:0] igbt,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            cfg_err,
  output logic [CW-1:0]   pulse_cnt,
  output logic [CW-1:0]   burst_cnt
);
  state_t state, state_nx;
  cfg_t cfg, cfg_nx;
  logic [TW-1:0] t, t_nx, t_inc;
  logic [TW+CW-1:0] b, b_nx, b_inc, bp_ext;
  logic [CW-1:0] pc, pc_nx, bc, bc_nx;
  logic [N_CH-1:0] ch, ch_nx;
  logic tick, restart, req, bad;
  logic fin_c, ab_c, err_c, fin_q, ab_q, err_q;
  us_tick_gen #(.DIV(CLK_PER_US)) u_tick (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .restart(restart), .tick(tick)
  );
  assign t_inc = t + TW'(1);
  assign b_inc = b + (TW+CW)'(1);
  assign bp_ext = {{CW{1'b0}}, cfg.burst_period};
  // Starts count only once the previous sequence has fully drained from the output stage.
  assign req = start && !stop && state == IDLE && !busy;
  assign bad = cfg_on_time == '0 || cfg_on_time >= cfg_pulse_period || cfg_pulses == '0
            || cfg_bursts == '0 || cfg_ch_mask == '0;
  always_comb begin
    state_nx = state;
    cfg_nx = cfg;
    t_nx = state != IDLE && tick ? t_inc : t;
    b_nx = state != IDLE && tick ? b_inc : b;
    pc_nx = pc;
    bc_nx = bc;
    ch_nx = ch;
    restart = 1'b0;
    fin_c = 1'b0;
    ab_c = 1'b0;
    err_c = 1'b0;
    if (state == IDLE) begin
      err_c = req && bad;
      if (req && !bad) begin
        cfg_nx = '{on_time: cfg_on_time, pulse_period: cfg_pulse_period, pulses: cfg_pulses,
                   burst_period: cfg_burst_period, bursts: cfg_bursts, ch_mask: cfg_ch_mask,
                   rotate: cfg_rotate};
        state_nx = ON;
        t_nx = '0;
        b_nx = '0;
        pc_nx = '0;
        bc_nx = '0;
        ch_nx = cfg_rotate ? next_ch(cfg_ch_mask, '0) : cfg_ch_mask;
        restart = 1'b1;
      end
    end else if (stop) begin
      state_nx = IDLE;
      ab_c = 1'b1;
    end else if (state == ON) begin
      if (tick && t_inc == cfg.on_time) state_nx = OFF;
    end else if (state == OFF) begin
      if (tick && t_inc == cfg.pulse_period) begin
        t_nx = '0;
        ch_nx = cfg.rotate ? next_ch(cfg.ch_mask, ch) : ch;
        state_nx = ON;
        pc_nx = pc + CW'(1);
        if (pc_nx == cfg.pulses) begin
          pc_nx = '0;
          bc_nx = bc + CW'(1);
          if (bc_nx == cfg.bursts) begin
            state_nx = IDLE;
            fin_c = 1'b1;
          end else if (bp_ext > b_inc) state_nx = GAP;
          else b_nx = '0;
        end
      end
    end else if (tick && b_inc == bp_ext) begin
      state_nx = ON;
      t_nx = '0;
      b_nx = '0;
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      cfg <= '0;
      t <= '0;
      b <= '0;
      pc <= '0;
      bc <= '0;
      ch <= '0;
      fin_q <= 1'b0;
      ab_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cfg <= cfg_nx;
      t <= t_nx;
      b <= b_nx;
      pc <= pc_nx;
      bc <= bc_nx;
      ch <= ch_nx;
      fin_q <= fin_c;
      ab_q <= ab_c;
      err_q <= err_c;
    end
  // Output stage: every pin is a flop fed from the sequencer state.
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      igbt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      cfg_err <= 1'b0;
      pulse_cnt <= '0;
      burst_cnt <= '0;
    end else begin
      igbt <= state == ON ? ch : '0;
      busy <= state != IDLE;
      done <= fin_q;
      aborted <= ab_q;
      cfg_err <= err_q;
      pulse_cnt <= pc;
      burst_cnt <= bc;
    end
endmodule

// File: doc/tms_pulse_seq.md
Name: tms_pulse_seq

Overview:
- Parametrised successor to the single-channel IGBT pulse logic.
- Generates timed drive pulses on up to N_CH IGBT outputs, organised as trains of pulses grouped into bursts, all timed on a 1 µs tick derived from sys_clk.
- Sits between the UART command decoder, which supplies the cfg_* fields and start/stop, and the IGBT gate-drive pins.
- Adds what the old block lacked: per-channel mask, channel rotation, pulse/burst counts, abort, and configuration checking.

Parameters:
- CLK_PER_US, 50, sys_clk cycles per 1 µs tick (50 MHz clock, 20 ns period).
- N_CH, 5, number of IGBT channels.
- TW, 24, width of all µs time fields and timers.
- CW, 8, width of pulse and burst count fields.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sequence.
- stop  in  1  one-cycle abort request.
- cfg_on_time  in  TW  pulse high time, µs.
- cfg_pulse_period  in  TW  rising-edge to rising-edge spacing within a burst, µs.
- cfg_pulses  in  CW  pulses per burst.
- cfg_burst_period  in  TW  first-edge to first-edge spacing of bursts, µs.
- cfg_bursts  in  CW  number of bursts.
- cfg_ch_mask  in  N_CH  enabled channels.
- cfg_rotate  in  1  0 = all masked channels fire together; 1 = one channel per pulse, rotating.
- igbt  out  N_CH  registered gate drive outputs.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when a running sequence is stopped.
- cfg_err  out  1  one-cycle pulse when a start is rejected.
- pulse_cnt  out  CW  pulses completed in the current burst.
- burst_cnt  out  CW  bursts completed.

Behaviour:
- Reset: all outputs are 0; the state machine is IDLE and all timers are 0. Reset is asynchronous, so asserting it mid-sequence drops igbt immediately.
- States:
  - IDLE waits for start.
  - ON: pulse high.
  - OFF: remainder of the pulse period.
  - GAP: wait for the next burst.
- Start acceptance:
  - A start sampled in IDLE with stop=0 latches all cfg_* fields; later cfg changes are ignored until the next IDLE.
  - The start is rejected when cfg_on_time==0, cfg_on_time>=cfg_pulse_period, cfg_pulses==0, cfg_bursts==0, or cfg_ch_mask==0.
  - A rejected start pulses cfg_err on the next cycle and the block stays in IDLE.
  - start while busy is ignored. start and stop in the same IDLE cycle: stop wins and nothing happens.
- Timing of an accepted start at edge k:
  - The µs prescaler restarts at 0.
  - busy=1 and the first pulse rises at k+1.
  - The pulse is high for exactly on_time*CLK_PER_US cycles.
  - The next rising edge follows pulse_period*CLK_PER_US cycles after the previous one.
- Burst spacing:
  - The next burst's first edge comes burst_period*CLK_PER_US cycles after the current burst's first edge, if burst_period >= pulses*pulse_period.
  - Otherwise bursts run back-to-back: the next first edge comes at the end of the last pulse period.
- Counters:
  - pulse_cnt increments at the end of each pulse period and clears to 0 when a burst ends.
  - burst_cnt increments when a burst ends.
- Completion: when the last pulse period of the last burst ends, busy=0 and done=1 in that same first-idle cycle. burst_cnt holds its final value until the next accepted start clears it.
- Channel selection:
  - cfg_rotate=0: igbt = cfg_ch_mask while ON, and 0 otherwise.
  - cfg_rotate=1: each pulse drives only one bit. The first pulse uses the lowest set mask bit; each following pulse uses the next set bit above it, wrapping to the lowest. Rotation continues across burst boundaries.
- Abort: stop while busy forces igbt=0 and busy=0 at the next edge, pulses aborted once, does not assert done, and returns the state machine to IDLE.
- Invariants: igbt is never high outside ON, and in rotate mode at most one bit is high.

Decomposition:
- tms_pulse_pkg holds:
  - the state enum (IDLE, ON, OFF, GAP);
  - default CLK_PER_US, TW, CW;
  - the config struct (on_time, pulse_period, pulses, burst_period, bursts, ch_mask, rotate).
- One sub-module, us_tick_gen: a prescaler with synchronous restart input that outputs a one-cycle tick every CLK_PER_US cycles.
- The next-set-bit search for rotate mode is a function in the package.

Test Plan (CLK_PER_US=50; start accepted at edge k):
- on=2, period=10, pulses=3, bursts=1, mask=00001, rotate=0 -> igbt[0] high for 100 cycles from k+1, k+501 and k+1001; busy falls and done pulses at k+1501; pulse_cnt steps 1,2, then 0 when the burst ends; burst_cnt=1.
- on=2, period=10, pulses=2, bursts=2, burst_period=100 -> second burst edges at k+5001 and k+5501; done at k+6001; burst_cnt=2.
- Same as above but burst_period=5 -> bursts back-to-back, edges at k+1, k+501, k+1001, k+1501; done at k+2001.
- rotate=1, mask=10101, pulses=4, bursts=1 -> pulses on igbt[0], igbt[2], igbt[4], igbt[0]; never two bits high at once.
- Running sequence, stop at k+50 -> igbt=0 and busy=0 at k+51, aborted pulses once, no done; a start at k+52 is accepted.
- on=10, period=10 -> cfg_err pulses, busy stays 0, igbt stays 0. Separately, assert sys_rst_n=0 mid-ON -> igbt drops without waiting for a clock edge and all outputs read 0.
